ysyx_sram_resp: RTL and testbench

Memory responder for the core's load/store path: the target end of the data-memory request/response interface that the execute stage drives. It accepts one request at a time, waits a programmable number of cycles, then performs a masked word write or a word read on internal storage and returns a response. It replaces direct simulator memory calls with a synthesizable, back-pressurable slave. The same block serves as the data-RAM model on the SoC bus.

---
 rtl/ysyx_sram_resp.sv | 118 +++++++++++
 tb/tb_ysyx_sram_resp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_sram_resp.sv
// ysyx_sram_resp: data-memory responder with programmable access latency.
// One request in flight; masked word write or word read on local storage.
module ysyx_sram_resp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int LAT   = (LATENCY < 1) ? 1 : LATENCY;
  localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            wen_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wmask_q;

  logic [31:0]     mem [DEPTH];

  logic [32:0]           off;
  logic [32:0]           lim;
  logic                  in_rng;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  access;
  logic                  unused_off;

  // 33-bit compare so addresses near 2^32 cannot wrap into range
  assign off    = {1'b0, addr_q} - {1'b0, BASE};
  assign lim    = 33'(DEPTH) << 2;
  assign in_rng = ({1'b0, addr_q} >= {1'b0, BASE}) && (off < lim);
  assign idx    = off[DEPTH_LOG2+1:2];
  assign access = (state == S_WAIT) && (cnt == '0);

  assign unused_off = ^{off[32:DEPTH_LOG2+2], off[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            wen_q     <= req_wen;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wmask_q   <= req_wmask;
            cnt       <= CW'(LAT - 1);
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= !in_rng;
            rsp_rdata <= (in_rng && !wen_q) ? mem[idx] : 32'h0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // storage has no reset; a reset forces IDLE so no write can follow it
  always_ff @(posedge clk) begin
    if (access && in_rng && wen_q) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask_q[k]) begin
          mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_sram_resp.sv
// tb_ysyx_sram_resp: table-driven and hand-sequenced checks
// for ysyx_sram_resp at latencies 2, 1 and 5.
module tb_ysyx_sram_resp;

  localparam int NI = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 5;
  endfunction

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_wen   [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_wmask [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ysyx_sram_resp #(.LATENCY(lat_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wen   (req_wen[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wmask (req_wmask[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  exp_t sb[$];

  function automatic vec_t mk(input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m,
                              input logic [31:0] r, input bit e);
    vec_t v;
    v.wen = w; v.addr = a; v.wdata = d;
    v.wmask = m; v.rdata = r; v.err = e;
    return v;
  endfunction

  task automatic xact(input int i, input vec_t v, output int acc);
    exp_t e;
    int   n;
    e.rdata = v.rdata;
    e.err   = v.err;
    sb.push_back(e);
    rsp_ready[i] = 1'b1;
    req_wen[i]   = v.wen;
    req_addr[i]  = v.addr;
    req_wdata[i] = v.wdata;
    req_wmask[i] = v.wmask;
    req_valid[i] = 1'b1;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("i%0d accept_timeout", i), 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    req_valid[i] = 1'b0;
    n = 0;
    while (rsp_valid[i] !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("i%0d latency a=%h", i, v.addr), 32'(n), 32'(lat_of(i)));
    e = sb.pop_front();
    chk($sformatf("i%0d rdata a=%h", i, v.addr), rsp_rdata[i], e.rdata);
    chk($sformatf("i%0d err a=%h", i, v.addr), 32'(rsp_err[i]), 32'(e.err));
    @(posedge clk); #1;
    chk($sformatf("i%0d rsp_drop", i), 32'(rsp_valid[i]), 32'd0);
    chk($sformatf("i%0d ready_back", i), 32'(req_ready[i]), 32'd1);
  endtask

  vec_t tbl[16];

  initial begin
    int acc;
    int prev;
    int n;
    logic [31:0] hold_d;
    vec_t v;

    tbl[0]  = mk(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
    tbl[1]  = mk(0, 32'h8000_0012, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    tbl[2]  = mk(1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, 0);
    tbl[3]  = mk(1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 0);
    tbl[4]  = mk(0, 32'h8000_0020, 32'h0, 4'hF, 32'h11BB_33DD, 0);
    tbl[5]  = mk(1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 0);
    tbl[6]  = mk(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1);
    tbl[7]  = mk(0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1);
    tbl[8]  = mk(1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1);
    tbl[9]  = mk(0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 0);
    tbl[10] = mk(1, 32'h8000_0020, 32'h0102_0304, 4'h0, 32'h0, 0);
    tbl[11] = mk(0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 0);
    tbl[12] = mk(1, 32'h8000_0FFC, 32'h1234_5678, 4'hF, 32'h0, 0);
    tbl[13] = mk(0, 32'h8000_0FFF, 32'h0, 4'h0, 32'h1234_5678, 0);
    tbl[14] = mk(0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1);
    tbl[15] = mk(1, 32'h8000_0030, 32'h1357_9BDF, 4'hF, 32'h0, 0);

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; rsp_ready[i] = 1'b1;
      req_wen[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_wmask[i] = '0;
    end
    #12;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d rst_ready", i), 32'(req_ready[i]), 32'd0);
      chk($sformatf("i%0d rst_valid", i), 32'(rsp_valid[i]), 32'd0);
      chk($sformatf("i%0d rst_rdata", i), rsp_rdata[i], 32'd0);
      chk($sformatf("i%0d rst_err", i), 32'(rsp_err[i]), 32'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++)
      chk($sformatf("i%0d ready_after_rst", i), 32'(req_ready[i]), 32'd1);

    // back-to-back table per latency; throughput is LATENCY+2
    for (int i = 0; i < NI; i++) begin
      prev = 0;
      for (int j = 0; j < 16; j++) begin
        xact(i, tbl[j], acc);
        if (j > 0)
          chk($sformatf("i%0d period j=%0d", i, j),
              32'(acc - prev), 32'(lat_of(i) + 2));
        prev = acc;
      end
    end

    // back-pressure with busy requests poking at 0x30/0x34
    xact(0, mk(1, 32'h8000_0034, 32'h1357_9BDF, 4'hF, 32'h0, 0), acc);
    rsp_ready[0] = 1'b0;
    req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0010;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 20) begin
      req_valid[0] = ~req_valid[0];
      req_wen[0] = 1'b1;
      req_addr[0] = 32'h8000_0030 + 32'(4 * (n % 2));
      req_wdata[0] = 32'hBAD0_0000 | 32'(n);
      req_wmask[0] = 4'hF;
      chk("bp wait_ready", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1; n++;
    end
    chk("bp wait_latency", 32'(n), 32'd2);
    hold_d = rsp_rdata[0];
    chk("bp rdata", hold_d, 32'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) begin
      req_valid[0] = ~req_valid[0];
      req_addr[0] = 32'h8000_0030 + 32'(4 * (k % 2));
      @(posedge clk); #1;
      chk("bp hold_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp hold_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
      chk("bp hold_err", 32'(rsp_err[0]), 32'd0);
      chk("bp hold_ready", 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp release_ready", 32'(req_ready[0]), 32'd1);
    xact(0, mk(0, 32'h8000_0030, 32'h0, 4'h0, 32'h1357_9BDF, 0), acc);
    xact(0, mk(0, 32'h8000_0034, 32'h0, 4'h0, 32'h1357_9BDF, 0), acc);

    // reset one cycle after accepting a write
    xact(0, mk(1, 32'h8000_0040, 32'h0, 4'hF, 32'h0, 0), acc);
    req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0040;
    req_wdata[0] = 32'h5555_5555; req_wmask[0] = 4'hF;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    #1;
    chk("rstw valid_in_rst", 32'(rsp_valid[0]), 32'd0);
    chk("rstw ready_in_rst", 32'(req_ready[0]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("rstw valid_after", 32'(rsp_valid[0]), 32'd0);
    @(posedge clk); #1;
    chk("rstw ready_after", 32'(req_ready[0]), 32'd1);
    v = mk(0, 32'h8000_0040, 32'h0, 4'h0, 32'h0, 0);
    xact(0, v, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
